// File: rtl/vga_text_buf_pkg.sv
// Shared constants and types for the VGA text buffer.
// ASCII control codes, the printable range and the controller state encoding.
package vga_text_pkg;

  localparam logic [7:0] ENTER    = 8'h0A;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    INIT       = 2'd0,
    IDLE       = 2'd1,
    SCROLL_CLR = 2'd2
  } state_t;

  // True for bytes that are stored as visible characters.
  function automatic logic is_print(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/vga_text_buf_if.sv
// Bus bundle for the VGA text buffer: keyboard byte handshake, renderer
// read port and debug visibility of the controller state.
//
// Handshake: key_in is consumed on any rising clk edge where p_valid and
// p_ready are both high; the source holds key_in stable and p_valid high
// until that edge, and p_ready may drop at any time without a byte in flight.
interface vga_text_buf_if #(
  parameter int COLS    = 70,
  parameter int ROWS    = 30,
  parameter int GLYPH_H = 16
);
  import vga_text_pkg::*;

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(GLYPH_H);

  // keyboard side
  logic [7:0]    key_in;
  logic          p_valid;
  logic          p_ready;
  logic          busy;
  // renderer side
  logic [CW-1:0] x;
  logic [RW-1:0] y;
  logic [9:0]    v_addr;
  logic [7:0]    ascii_out;
  logic [HW-1:0] row;
  logic          cursor_on;
  // debug view of the controller
  state_t        dbg_state;
  logic [CW-1:0] dbg_cx;
  logic [RW-1:0] dbg_cy;
  logic [RW-1:0] dbg_top;

  modport master (
    output key_in, p_valid, x, y, v_addr,
    input  p_ready, busy, ascii_out, row, cursor_on,
    input  dbg_state, dbg_cx, dbg_cy, dbg_top
  );

  modport slave (
    input  key_in, p_valid, x, y, v_addr,
    output p_ready, busy, ascii_out, row, cursor_on,
    output dbg_state, dbg_cx, dbg_cy, dbg_top
  );

endinterface

// File: rtl/vga_text_buf_text_ram.sv
// Character storage: one synchronous write port, one synchronous read port.
// A same-cycle read of the cell being written returns the previous contents.
// rclr forces the registered read data to 0 (used for off-screen reads).
module text_ram #(
  parameter int DEPTH = 2100,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port with synchronous clear
  always_ff @(posedge clk) begin
    if (rst || rclr) rdata <= 8'h00;
    else             rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_text_buf.sv
// Character-cell video memory for the VGA text console.
// Places keyboard bytes at a hardware cursor (newline, backspace, wrap),
// scrolls by advancing a ring-buffer top-row pointer and clearing the row
// that becomes the bottom line, and serves the renderer with 1-cycle reads.
// Optional feature macro: CURSOR_BLINK_EN (blinking cursor overlay).
module vga_text_buf
  import vga_text_pkg::*;
#(
  parameter int COLS    = 70,
  parameter int ROWS    = 30,
  parameter int GLYPH_H = 16
) (
  input logic           clk,
  input logic           reset,
  vga_text_buf_if.slave bus
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int HW    = $clog2(GLYPH_H);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CW-1:0] LAST_COL     = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW     = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_CELL    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_CLR_COL = AW'(COLS - 1);

  state_t        state;
  logic [CW-1:0] cx;
  logic [RW-1:0] cy;
  logic [RW-1:0] top;
  logic [AW-1:0] clr_cnt;
  logic          ready_q;
  logic          busy_q;

  logic          accept;
  logic          is_nl;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          in_range;
  logic [AW-1:0] raddr;
  logic [7:0]    ascii_q;
  logic [HW-1:0] row_q;

  // Physical memory row of screen row s: top+s folded back into 0..ROWS-1.
  function automatic logic [RW-1:0] prow(input logic [RW-1:0] t, input logic [RW-1:0] s);
    logic [RW:0] sum;
    sum = {1'b0, t} + {1'b0, s};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    return sum[RW-1:0];
  endfunction

  // Linear cell address of physical row r, column c.
  function automatic logic [AW-1:0] lin(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign accept = (state == IDLE) && ready_q && bus.p_valid;

  // Decode bytes that move the cursor to the start of the next line.
  always_comb begin
    is_nl = 1'b0;
    if (bus.key_in == ENTER) is_nl = 1'b1;
    else if (is_print(bus.key_in) && (cx == LAST_COL)) is_nl = 1'b1;
  end

  // Write-port mux: clear sweeps in INIT/SCROLL_CLR, key writes in IDLE.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = 8'h00;
    case (state)
      INIT: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      SCROLL_CLR: begin
        we    = 1'b1;
        waddr = lin(prow(top, LAST_ROW), clr_cnt[CW-1:0]);
      end
      IDLE: begin
        if (accept) begin
          if (is_print(bus.key_in)) begin
            we    = 1'b1;
            waddr = lin(prow(top, cy), cx);
            wdata = bus.key_in;
          end else if (bus.key_in == BS) begin
            if (cx != '0) begin
              we    = 1'b1;
              waddr = lin(prow(top, cy), cx - CW'(1));
            end else if (cy != '0) begin
              we    = 1'b1;
              waddr = lin(prow(top, cy - RW'(1)), LAST_COL);
            end
          end
        end
      end
      default: ;
    endcase
    if (reset) we = 1'b0;
  end

  // Controller FSM: clear sweep, key handling, scroll clear; registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      cx      <= '0;
      cy      <= '0;
      top     <= '0;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == LAST_CELL) begin
            clr_cnt <= '0;
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        SCROLL_CLR: begin
          if (clr_cnt == LAST_CLR_COL) begin
            clr_cnt <= '0;
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (is_nl) begin
              cx <= '0;
              if (cy != LAST_ROW) begin
                cy <= cy + RW'(1);
              end else begin
                top     <= (top == LAST_ROW) ? '0 : top + RW'(1);
                clr_cnt <= '0;
                state   <= SCROLL_CLR;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end else if (is_print(bus.key_in)) begin
              cx <= cx + CW'(1);
            end else if (bus.key_in == BS) begin
              if (cx != '0) begin
                cx <= cx - CW'(1);
              end else if (cy != '0) begin
                cx <= LAST_COL;
                cy <= cy - RW'(1);
              end
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Renderer address: off-screen coordinates read as blank.
  always_comb begin
    in_range = (32'(bus.x) < COLS) && (32'(bus.y) < ROWS);
    raddr    = in_range ? lin(prow(top, bus.y), bus.x) : '0;
  end

  text_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (reset),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .rclr (!in_range),
    .raddr(raddr),
    .rdata(ascii_q)
  );

  // Glyph pixel row, aligned with the character read.
  always_ff @(posedge clk) begin
    if (reset) row_q <= '0;
    else       row_q <= HW'(bus.v_addr - 10'(32'(bus.y) * GLYPH_H));
  end

`ifdef CURSOR_BLINK_EN
  logic [23:0] blink_cnt;
  logic        cursor_q;

  // Free-running blink counter; its MSB is the blink phase.
  always_ff @(posedge clk) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_cnt + 24'd1;
  end

  // Cursor overlay, aligned with ascii_out.
  always_ff @(posedge clk) begin
    if (reset) cursor_q <= 1'b0;
    else       cursor_q <= (bus.x == cx) && (bus.y == cy) && blink_cnt[23];
  end

  assign bus.cursor_on = cursor_q;
`else
  assign bus.cursor_on = 1'b0;
`endif

  assign bus.p_ready   = ready_q;
  assign bus.busy      = busy_q;
  assign bus.ascii_out = ascii_q;
  assign bus.row       = row_q;
  assign bus.dbg_state = state;
  assign bus.dbg_cx    = cx;
  assign bus.dbg_cy    = cy;
  assign bus.dbg_top   = top;

endmodule

// File: tb/tb_vga_text_buf.sv
// Bench for vga_text_buf: keyboard driver, renderer probes, and a scoreboard
// fed from a screen-coordinate model of the console.
module tb_vga_text_buf;
  import vga_text_pkg::*;

  localparam int COLS    = 70;
  localparam int ROWS    = 30;
  localparam int GLYPH_H = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_text_buf_if #(.COLS(COLS), .ROWS(ROWS), .GLYPH_H(GLYPH_H)) bus();

  vga_text_buf #(.COLS(COLS), .ROWS(ROWS), .GLYPH_H(GLYPH_H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // expected {ascii, row} per issued probe
  logic [11:0] exp_q[$];
  logic [11:0] exp_e;
  logic        rd_issue = 1'b0;
  logic        rd_q     = 1'b0;

  // model: screen contents in screen coordinates, cursor and top pointer
  logic [7:0] scr [ROWS][COLS];
  int m_cx, m_cy, m_top;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  function automatic logic [11:0] model_read(input int px, input int py, input int pv);
    logic [7:0] a;
    logic [3:0] r;
    a = (px < COLS && py < ROWS) ? scr[py][px] : 8'h00;
    r = 4'((pv - py * GLYPH_H) & (GLYPH_H - 1));
    return {a, r};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    m_cx = 0; m_cy = 0; m_top = 0;
  endtask

  task automatic model_newline(output bit sc);
    sc = 1'b0;
    m_cx = 0;
    if (m_cy < ROWS - 1) begin
      m_cy++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
      m_top = (m_top + 1) % ROWS;
      sc = 1'b1;
    end
  endtask

  task automatic model_key(input logic [7:0] k, output bit sc);
    sc = 1'b0;
    if (k >= 8'h20 && k <= 8'h7E) begin
      scr[m_cy][m_cx] = k;
      if (m_cx == COLS - 1) model_newline(sc);
      else m_cx++;
    end else if (k == 8'h0A) begin
      model_newline(sc);
    end else if (k == 8'h08) begin
      if (m_cx > 0) begin
        m_cx--;
        scr[m_cy][m_cx] = 8'h00;
      end else if (m_cy > 0) begin
        m_cy--;
        m_cx = COLS - 1;
        scr[m_cy][m_cx] = 8'h00;
      end
    end
  endtask

  // monitor: compares the registered read one cycle after each probe
  always @(posedge clk) rd_q <= rd_issue;

  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        fail("read_queue_empty");
      end else begin
        exp_e = exp_q.pop_front();
        chk("ascii_out", int'(bus.ascii_out), int'(exp_e[11:4]));
        chk("row", int'(bus.row), int'(exp_e[3:0]));
`ifndef CURSOR_BLINK_EN
        chk("cursor_on", int'(bus.cursor_on), 0);
`endif
      end
    end
  end

  // driver: present one renderer coordinate
  task automatic probe(input int px, input int py, input int pv);
    @(negedge clk);
    bus.x      = 7'(px);
    bus.y      = 5'(py);
    bus.v_addr = 10'(pv);
    exp_q.push_back(model_read(px, py, pv));
    rd_issue = 1'b1;
  endtask

  task automatic probe_row(input int py);
    for (int c = 0; c < COLS; c++) probe(c, py, $urandom_range(0, 1023));
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++) probe_row(r);
  endtask

  // driver: send one keyboard byte and wait until the block is ready again
  task automatic send_key(input logic [7:0] k);
    bit sc;
    bit ok;
    int n;
    @(negedge clk);
    rd_issue    = 1'b0;
    bus.key_in  = k;
    bus.p_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.p_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail("key_accept");
      bus.p_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.p_valid = 1'b0;
    model_key(k, sc);
    n = 0;
    while (!bus.p_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("ready_low_cycles", n, sc ? COLS : 0);
    chk("cursor_x", int'(bus.dbg_cx), m_cx);
    chk("cursor_y", int'(bus.dbg_cy), m_cy);
    chk("top", int'(bus.dbg_top), m_top);
  endtask

  // driver: reset for two cycles; abort > 0 returns mid-clear
  task automatic apply_reset(input int abort);
    int n;
    @(negedge clk);
    rd_issue    = 1'b0;
    reset       = 1'b1;
    bus.p_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ascii_out", int'(bus.ascii_out), 0);
    chk("rst_row", int'(bus.row), 0);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_p_ready", int'(bus.p_ready), 0);
    chk("rst_cursor", int'(bus.dbg_cx) + int'(bus.dbg_cy), 0);
    chk("rst_top", int'(bus.dbg_top), 0);
    chk("rst_state", int'(bus.dbg_state), int'(INIT));
    model_clear();
    reset = 1'b0;
    if (abort > 0) begin
      repeat (abort) @(negedge clk);
      chk("mid_clear_busy", int'(bus.busy), 1);
      chk("mid_clear_p_ready", int'(bus.p_ready), 0);
      return;
    end
    n = 0;
    while (bus.busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", n, ROWS * COLS);
    chk("ready_after_clear", int'(bus.p_ready), 1);
    chk("state_after_clear", int'(bus.dbg_state), int'(IDLE));
  endtask

  // watchdog
  initial begin
    #3ms;
    $display("FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // stimulus
  initial begin
    logic [7:0] k;
    int r;
    reset       = 1'b1;
    bus.key_in  = 8'h00;
    bus.p_valid = 1'b0;
    bus.x       = '0;
    bus.y       = '0;
    bus.v_addr  = '0;

    // reset mid-clear, then a full clear; every cell must read 0
    apply_reset(500);
    apply_reset(0);
    sweep();

    // typing
    send_key(8'h41);
    send_key(8'h42);
    probe(0, 0, 0);
    probe(1, 0, 7);
    probe(2, 0, 9);
    @(negedge clk);
    rd_issue = 1'b0;
    chk("cursor_after_AB", int'(bus.dbg_cx), 2);

    // wrap and backspace
    apply_reset(0);
    for (int i = 0; i < COLS; i++) send_key(8'h61);
    chk("wrap_cursor_y", int'(bus.dbg_cy), 1);
    probe(COLS - 1, 0, 0);
    probe(0, 1, 0);
    send_key(8'h08);
    chk("bs_wrap_cursor_x", int'(bus.dbg_cx), COLS - 1);
    probe(COLS - 1, 0, 0);
    probe(COLS - 2, 0, 0);
    for (int i = 0; i < COLS - 1; i++) send_key(8'h08);
    send_key(8'h08);
    chk("bs_origin_cursor", int'(bus.dbg_cx) + int'(bus.dbg_cy), 0);
    probe_row(0);

    // fill every row, then scroll
    for (int rr = 0; rr < ROWS; rr++) begin
      send_key(8'(8'h30 + rr));
      send_key(8'(8'h41 + (rr % 26)));
      if (rr < ROWS - 1) send_key(8'h0A);
    end
    send_key(8'h0A);
    chk("top_after_scroll", int'(bus.dbg_top), 1);
    probe_row(0);
    probe_row(ROWS - 1);
    sweep();

    // glyph row and off-screen reads
    probe(0, 3, 53);
    probe(75, 0, 0);
    probe(127, 2, 40);
    probe(5, 31, 1000);
    probe(COLS - 1, ROWS - 1, 479);

    // randomized keys with interleaved probes
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = 8'($urandom_range(32, 126));
      else if (r < 70) k = 8'h0A;
      else if (r < 85) k = 8'h08;
      else             k = 8'($urandom_range(0, 255));
      send_key(k);
      if ($urandom_range(0, 1) == 1)
        probe($urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0)
        probe(m_cx, m_cy, $urandom_range(0, 1023));
    end
    sweep();

    @(negedge clk);
    rd_issue = 1'b0;
    repeat (3) @(negedge clk);
    chk("pending_reads", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
